// File: rtl/fpsr_timer_ctrl.sv
// Game timing scheduler: single-clock tick enable, elapsed-time counter
// and quiz countdown, all clock-enabled from board_clk.
module fpsr_timer_ctrl #(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned QUIZ_SECS = 10
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       q_INI,
    input  logic       q_GAME,
    input  logic       q_QUIZ,
    input  logic       q_WIN,
    input  logic       q_LOSE,
    output logic       tick,
    output logic [7:0] elapsed,
    output logic [3:0] quiz_left,
    output logic       quiz_timeout,
    output logic       frozen,
    output logic [1:0] tstate
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST   = PW'(TICK_DIV - 1);
    localparam logic [3:0]    QUIZ_LOAD = 4'(QUIZ_SECS);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_QUIZ = 2'b10,
        S_DONE = 2'b11
    } tstate_e;

    tstate_e       state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [7:0]    elapsed_q, elapsed_d;
    logic [3:0]    qleft_q, qleft_d;
    logic          tmo_q, tmo_d;
    logic          frozen_q, frozen_d;

    logic end_game;
    logic wrap;

    assign end_game = q_WIN | q_LOSE;
    assign wrap     = ((state_q == S_RUN) || (state_q == S_QUIZ)) && (presc_q == PS_LAST);

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            elapsed_q <= '0;
            qleft_q   <= '0;
            tmo_q     <= 1'b0;
            frozen_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            elapsed_q <= elapsed_d;
            qleft_q   <= qleft_d;
            tmo_q     <= tmo_d;
            frozen_q  <= frozen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (q_INI) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (q_GAME) state_d = S_RUN;
                S_RUN:  if (end_game) state_d = S_DONE;
                        else if (q_QUIZ) state_d = S_QUIZ;
                S_QUIZ: if (end_game) state_d = S_DONE;
                        else if (!q_QUIZ) state_d = S_RUN;
                default: state_d = S_DONE;
            endcase
        end
    end

    // State transitions take priority over a coincident wrap, which is dropped.
    always_comb begin
        presc_d   = presc_q;
        tick_d    = 1'b0;
        tmo_d     = 1'b0;
        elapsed_d = elapsed_q;
        qleft_d   = qleft_q;
        frozen_d  = (state_d == S_DONE);
        if (q_INI) begin
            presc_d   = '0;
            elapsed_d = '0;
            qleft_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: presc_d = '0;
                S_RUN: begin
                    if (end_game) begin
                        presc_d = presc_q;
                    end else if (q_QUIZ) begin
                        presc_d = '0;
                        qleft_d = QUIZ_LOAD;
                    end else if (wrap) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (elapsed_q != 8'hFF) elapsed_d = elapsed_q + 8'd1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_QUIZ: begin
                    if (end_game) begin
                        presc_d = presc_q;
                    end else if (!q_QUIZ) begin
                        presc_d = '0;
                        qleft_d = '0;
                    end else if (wrap) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (qleft_q != 4'd0) begin
                            qleft_d = qleft_q - 4'd1;
                            tmo_d   = (qleft_q == 4'd1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: presc_d = presc_q;
            endcase
        end
    end

    assign tick         = tick_q;
    assign elapsed      = elapsed_q;
    assign quiz_left    = qleft_q;
    assign quiz_timeout = tmo_q;
    assign frozen       = frozen_q;
    assign tstate       = state_q;

endmodule

// File: tb/tb_fpsr_timer_ctrl.sv
// Directed bench for fpsr_timer_ctrl with TICK_DIV=4, QUIZ_SECS=3.
module tb_fpsr_timer_ctrl;

    logic       board_clk;
    logic       Reset;
    logic       q_INI, q_GAME, q_QUIZ, q_WIN, q_LOSE;
    logic       tick;
    logic [7:0] elapsed;
    logic [3:0] quiz_left;
    logic       quiz_timeout;
    logic       frozen;
    logic [1:0] tstate;
    logic [16:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_QUIZ = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    fpsr_timer_ctrl #(.TICK_DIV(4), .QUIZ_SECS(3)) dut (
        .board_clk    (board_clk),
        .Reset        (Reset),
        .q_INI        (q_INI),
        .q_GAME       (q_GAME),
        .q_QUIZ       (q_QUIZ),
        .q_WIN        (q_WIN),
        .q_LOSE       (q_LOSE),
        .tick         (tick),
        .elapsed      (elapsed),
        .quiz_left    (quiz_left),
        .quiz_timeout (quiz_timeout),
        .frozen       (frozen),
        .tstate       (tstate)
    );

    // Packed view: {tick, elapsed, quiz_left, quiz_timeout, frozen, tstate}
    assign obs = {tick, elapsed, quiz_left, quiz_timeout, frozen, tstate};

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    function automatic logic [16:0] ex(input bit t, input int el, input int ql,
                                       input bit to, input bit fr, input logic [1:0] st);
        return {t, 8'(el), 4'(ql), to, fr, st};
    endfunction

    task automatic step;
        @(posedge board_clk);
        #1;
    endtask

    task automatic test_reset;
        logic [16:0] e;
        Reset = 1'b1;
        q_INI = 0; q_GAME = 0; q_QUIZ = 0; q_WIN = 0; q_LOSE = 0;
        #2;
        e = ex(0, 0, 0, 0, 0, ST_IDLE);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL reset_async: got %h want %h", obs, e);
        end
        step; step;
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_idle_hold k=%0d: got %h want %h", k, obs, e);
            end
        end
    endtask

    task automatic test_run;
        logic [16:0] e;
        q_GAME = 1;
        step;
        e = ex(0, 0, 0, 0, 0, ST_RUN);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL run_entry: got %h want %h", obs, e);
        end
        for (int k = 1; k <= 20; k++) begin
            step;
            e = ex((k % 4) == 0, k / 4, 0, 0, 0, ST_RUN);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL run_tick k=%0d: got %h want %h", k, obs, e);
            end
        end
    endtask

    task automatic test_quiz;
        logic [16:0] e;
        int ql;
        q_QUIZ = 1;
        step;
        e = ex(0, 5, 3, 0, 0, ST_QUIZ);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL quiz_entry: got %h want %h", obs, e);
        end
        for (int k = 1; k <= 16; k++) begin
            step;
            ql = (k / 4 >= 3) ? 0 : 3 - k / 4;
            e = ex((k % 4) == 0, 5, ql, k == 12, 0, ST_QUIZ);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL quiz_count k=%0d: got %h want %h", k, obs, e);
            end
        end
    endtask

    task automatic test_quiz_wrap_collision;
        logic [16:0] e;
        q_QUIZ = 0;
        for (int k = 0; k < 4; k++) begin
            step;
            e = ex(0, 5, 0, 0, 0, ST_RUN);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL collide_run k=%0d: got %h want %h", k, obs, e);
            end
        end
        q_QUIZ = 1;
        step;
        e = ex(0, 5, 3, 0, 0, ST_QUIZ);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL collide_quiz: got %h want %h", obs, e);
        end
    endtask

    task automatic test_quiz_drop;
        logic [16:0] e;
        for (int k = 1; k <= 4; k++) begin
            step;
            e = ex(k == 4, 5, (k == 4) ? 2 : 3, 0, 0, ST_QUIZ);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL drop_quiz k=%0d: got %h want %h", k, obs, e);
            end
        end
        q_QUIZ = 0;
        step;
        e = ex(0, 5, 0, 0, 0, ST_RUN);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL drop_entry: got %h want %h", obs, e);
        end
        for (int k = 1; k <= 4; k++) begin
            step;
            e = ex(k == 4, (k == 4) ? 6 : 5, 0, 0, 0, ST_RUN);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL drop_resume k=%0d: got %h want %h", k, obs, e);
            end
        end
    endtask

    task automatic test_saturate_win;
        logic [16:0] e;
        for (int k = 0; k < 992; k++) step;
        e = ex(1, 254, 0, 0, 0, ST_RUN);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL sat_254: got %h want %h", obs, e);
        end
        for (int t = 0; t < 3; t++) begin
            for (int k = 1; k <= 4; k++) begin
                step;
                e = ex(k == 4, (t == 0 && k < 4) ? 254 : 255, 0, 0, 0, ST_RUN);
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL sat_255 t=%0d k=%0d: got %h want %h", t, k, obs, e);
                end
            end
        end
        q_GAME = 0; q_WIN = 1;
        for (int k = 0; k < 9; k++) begin
            step;
            e = ex(0, 255, 0, 0, 1, ST_DONE);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL win_frozen k=%0d: got %h want %h", k, obs, e);
            end
        end
        q_WIN = 0; q_INI = 1;
        step;
        e = ex(0, 0, 0, 0, 0, ST_IDLE);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL win_ini: got %h want %h", obs, e);
        end
        q_INI = 0;
    endtask

    task automatic test_lose_quiz;
        logic [16:0] e;
        q_GAME = 1;
        step;
        q_QUIZ = 1;
        step;
        for (int k = 0; k < 4; k++) step;
        e = ex(1, 0, 2, 0, 0, ST_QUIZ);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL lose_pre: got %h want %h", obs, e);
        end
        q_LOSE = 1;
        for (int k = 0; k < 7; k++) begin
            step;
            e = ex(0, 0, 2, 0, 1, ST_DONE);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL lose_frozen k=%0d: got %h want %h", k, obs, e);
            end
        end
        q_INI = 1;
        step;
        e = ex(0, 0, 0, 0, 0, ST_IDLE);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL lose_ini_priority: got %h want %h", obs, e);
        end
        q_INI = 0; q_LOSE = 0; q_QUIZ = 0; q_GAME = 0;
        step;
    endtask

    task automatic test_reset_midquiz;
        logic [16:0] e;
        q_GAME = 1; q_QUIZ = 1;
        step;
        e = ex(0, 0, 0, 0, 0, ST_RUN);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL both_run_first: got %h want %h", obs, e);
        end
        step;
        e = ex(0, 0, 3, 0, 0, ST_QUIZ);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL both_quiz_next: got %h want %h", obs, e);
        end
        for (int k = 0; k < 6; k++) step;
        e = ex(0, 0, 2, 0, 0, ST_QUIZ);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL midq_pre: got %h want %h", obs, e);
        end
        #2 Reset = 1'b1;
        #1;
        e = ex(0, 0, 0, 0, 0, ST_IDLE);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL midq_async: got %h want %h", obs, e);
        end
        q_GAME = 0; q_QUIZ = 0;
        step; step;
        Reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step;
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL midq_after k=%0d: got %h want %h", k, obs, e);
            end
        end
    endtask

    initial begin
        test_reset;
        test_run;
        test_quiz;
        test_quiz_wrap_collision;
        test_quiz_drop;
        test_saturate_win;
        test_lose_quiz;
        test_reset_midquiz;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpsr_timer_ctrl.md
Name: fpsr_timer_ctrl

Overview:
Timing scheduler for the first-person-second-row game. Replaces the free-running divided-clock "minutes" counter and its gated-clock increment. Generates a single-cycle tick enable and keeps the elapsed-game-time counter, which pauses during quizzes and freezes on win or lose. Also runs the quiz answer countdown and flags a timeout. Everything is synchronous to board_clk; no derived clocks.

Parameters:
TICK_DIV, 100000000, board_clk cycles per tick (1 s at 100 MHz); must be >= 2
QUIZ_SECS, 10, quiz countdown load value in ticks; range 1..15

Ports:
board_clk  input  1  system clock, 100 MHz
Reset  input  1  asynchronous, active-high reset
q_INI  input  1  game FSM in INI state (one-hot, synchronous to board_clk)
q_GAME  input  1  game FSM in any GAME state
q_QUIZ  input  1  game FSM in any QUIZ state
q_WIN  input  1  game FSM in WIN state
q_LOSE  input  1  game FSM in LOSE state
tick  output  1  one-cycle pulse each TICK_DIV cycles while counting
elapsed  output  8  elapsed game ticks, binary, saturating (drives "minutes")
quiz_left  output  4  quiz ticks remaining
quiz_timeout  output  1  one-cycle pulse when quiz_left reaches 0
frozen  output  1  high in DONE state
tstate  output  2  FSM state: 00 IDLE, 01 RUN, 10 QUIZ, 11 DONE

Behaviour:
- Reset (async): state IDLE, prescaler 0, tick 0, elapsed 0, quiz_left 0, quiz_timeout 0, frozen 0, tstate 00.
- All outputs are registered. tick and quiz_timeout are high for exactly one cycle.
- Prescaler: counts 0..TICK_DIV-1 only in RUN or QUIZ. A "wrap" is the cycle in which prescaler == TICK_DIV-1; on that cycle it returns to 0. tick is asserted the cycle after a wrap.
- Evaluation priority each cycle: q_INI > (q_WIN|q_LOSE) > q_QUIZ edge > wrap.
- Any state with q_INI=1: next state IDLE. Clear prescaler, elapsed and quiz_left; tick=0.
- IDLE: prescaler held at 0. q_GAME=1 -> RUN with prescaler 0, so the first tick comes TICK_DIV cycles after RUN is entered.
- RUN:
  - wrap -> elapsed+1, saturating at 255 (no wrap to 0).
  - q_QUIZ=1 -> QUIZ. quiz_left loads QUIZ_SECS and prescaler clears. A wrap in the same cycle is discarded: no tick, no elapsed increment.
- QUIZ:
  - elapsed is held.
  - wrap with quiz_left > 0 -> quiz_left-1 and tick pulses.
  - The decrement from 1 to 0 also pulses quiz_timeout in the same cycle as tick.
  - At quiz_left = 0, further wraps produce a tick only; quiz_left stays 0 and there is no further timeout.
  - q_QUIZ=0 -> RUN. quiz_left clears to 0, prescaler clears, elapsed resumes from its held value.
- q_WIN|q_LOSE in RUN or QUIZ -> DONE.
- DONE: prescaler stopped; elapsed and quiz_left hold their values; tick=0; frozen=1. Leave only via q_INI (-> IDLE) or Reset.
- Reset asserted mid-count aborts immediately: all registers go to their reset values, with no partial tick or timeout pulse.
- q_GAME and q_QUIZ both high in IDLE: go to RUN first; QUIZ is entered on the following cycle.

Test Plan:
- TICK_DIV=4: Reset, then q_GAME=1 -> tstate=01; tick pulses at cycles 4, 8, 12 after RUN entry; elapsed reads 1, 2, 3.
- TICK_DIV=4, QUIZ_SECS=3: elapsed=5 in RUN, raise q_QUIZ -> quiz_left=3; quiz_left goes 2, 1, 0 on successive ticks; quiz_timeout pulses once with the 1->0 tick; elapsed stays 5 throughout.
- q_QUIZ raised in the same cycle as a RUN wrap -> no tick, elapsed unchanged, tstate=10, quiz_left=QUIZ_SECS.
- q_QUIZ dropped with quiz_left=2 -> tstate=01, quiz_left=0; first tick 4 cycles later; elapsed increments from its held value.
- Force elapsed to 254, run 3 ticks -> elapsed 255, 255, 255; then q_WIN -> frozen=1, no further ticks; then q_INI -> tstate=00, elapsed=0.
- Assert Reset mid-prescaler in QUIZ with quiz_left=2 -> all outputs 0 the same cycle; no quiz_timeout pulse after release.
